artec_dma_axi_wr: RTL and testbench

ARTEC_DMA_AXI_WR -- requirements
Module: artec_dma_axi_wr

---
 rtl/artec_dma_axi_wr.sv | 175 +++++++++++++++++
 tb/tb_artec_dma_axi_wr.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/artec_dma_axi_wr.sv
// artec_dma_axi_wr
//   Turns arbiter write tasks (channel idx, address, beat count) plus a data
//   stream into AXI4 INCR write bursts, and reports each burst's B response
//   back to the originating channel in issue order.
//
// Ports
//   clk, rstn, clear               : single clock, async active-low reset,
//                                    synchronous clear (AXI side quiescent)
//   task_valid/ready/idx/addr/num  : task stream, num==0 means 256 beats
//   data_valid/ready, data         : write data stream
//   aw*                            : AXI4 write-address channel
//   w*                             : AXI4 write-data channel
//   b*                             : AXI4 write-response channel
//   done_valid/ready/idx/err       : per-burst completion report
module artec_dma_axi_wr #(
  parameter int CH_NUM    = 4,
  parameter int CH_NUM_L  = 2,
  parameter int DW        = 64,
  parameter int AW        = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                clear,
  input  logic                task_valid,
  output logic                task_ready,
  input  logic [CH_NUM_L-1:0] task_idx,
  input  logic [AW-1:0]       task_addr,
  input  logic [7:0]          task_num,
  input  logic                data_valid,
  output logic                data_ready,
  input  logic [DW-1:0]       data,
  output logic                awvalid,
  input  logic                awready,
  output logic [AW-1:0]       awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                wvalid,
  input  logic                wready,
  output logic [DW-1:0]       wdata,
  output logic [DW/8-1:0]     wstrb,
  output logic                wlast,
  input  logic                bvalid,
  output logic                bready,
  input  logic [1:0]          bresp,
  output logic                done_valid,
  input  logic                done_ready,
  output logic [CH_NUM_L-1:0] done_idx,
  output logic                done_err
);

  localparam int SZ = $clog2(DW/8);
  localparam int CW = $clog2(MAX_OUTST+1);
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  if (CH_NUM_L != $clog2(CH_NUM)) begin : g_bad_idx_width
    $error("CH_NUM_L must equal clog2(CH_NUM)");
  end

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       addr_q;
  logic [7:0]          len_q;
  logic [7:0]          beat_q;
  logic [CW-1:0]       outst_q;
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CH_NUM_L-1:0] fifo_q [MAX_OUTST];
  logic                done_valid_q;
  logic [CH_NUM_L-1:0] done_idx_q;
  logic                done_err_q;

  logic task_hs, aw_hs, w_hs, b_hs, bready_int;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTST-1)) ? '0 : p + 1'b1;
  endfunction

  // rstn gates the task side so nothing is accepted while in reset.
  assign task_ready = rstn && (state_q == IDLE) && (outst_q < CW'(MAX_OUTST)) && !clear;
  assign task_hs    = task_valid && task_ready;

  assign awvalid = (state_q == ADDR);
  assign awaddr  = addr_q;
  assign awlen   = len_q;
  assign awsize  = 3'(SZ);
  assign awburst = 2'b01;
  assign aw_hs   = awvalid && awready;

  assign wvalid     = (state_q == DATA) && data_valid;
  assign data_ready = (state_q == DATA) && wready;
  assign wdata      = data & {DW{rstn}};
  assign wstrb      = '1;
  assign wlast      = (state_q == DATA) && (beat_q == len_q);
  assign w_hs       = wvalid && wready;

  // Stray B with nothing outstanding is never accepted; during reset the
  // port idles high.
  assign bready_int = (outst_q != '0) && (!done_valid_q || done_ready);
  assign bready     = !rstn || bready_int;
  assign b_hs       = bvalid && bready_int && !clear;

  assign done_valid = done_valid_q;
  assign done_idx   = done_idx_q;
  assign done_err   = done_err_q;

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (task_hs)       state_d = ADDR;
        ADDR:    if (aw_hs)         state_d = DATA;
        DATA:    if (w_hs && wlast) state_d = IDLE;
        default:                    state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      beat_q       <= '0;
      outst_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      done_valid_q <= 1'b0;
      done_idx_q   <= '0;
      done_err_q   <= 1'b0;
      for (int i = 0; i < MAX_OUTST; i++) fifo_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (task_hs) begin
        addr_q <= task_addr;
        len_q  <= task_num - 8'd1;  // 0 wraps to 255 -> 256 beats
      end
      if (clear) begin
        outst_q      <= '0;
        beat_q       <= '0;
        wr_ptr_q     <= '0;
        rd_ptr_q     <= '0;
        done_valid_q <= 1'b0;
      end else begin
        if (aw_hs)     beat_q <= '0;
        else if (w_hs) beat_q <= beat_q + 8'd1;

        case ({task_hs, b_hs})
          2'b10:   outst_q <= outst_q + 1'b1;
          2'b01:   outst_q <= outst_q - 1'b1;
          default: ;
        endcase

        // Index FIFO keeps B responses matched to channels in issue order.
        if (task_hs) begin
          fifo_q[wr_ptr_q] <= task_idx;
          wr_ptr_q         <= ptr_inc(wr_ptr_q);
        end

        if (b_hs) begin
          rd_ptr_q     <= ptr_inc(rd_ptr_q);
          done_valid_q <= 1'b1;
          done_idx_q   <= fifo_q[rd_ptr_q];
          done_err_q   <= (bresp != 2'b00);
        end else if (done_ready) begin
          done_valid_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_artec_dma_axi_wr.sv
module tb_artec_dma_axi_wr;

  logic        clk = 1'b0;
  logic        rstn, clear;
  logic        task_valid, task_ready;
  logic [1:0]  task_idx;
  logic [31:0] task_addr;
  logic [7:0]  task_num;
  logic        data_valid, data_ready;
  logic [63:0] data;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        done_valid, done_ready;
  logic [1:0]  done_idx;
  logic        done_err;

  int n_tests = 0;
  int n_fail  = 0;

  artec_dma_axi_wr #(.CH_NUM(4), .CH_NUM_L(2), .DW(64), .AW(32), .MAX_OUTST(4)) dut (
    .clk(clk), .rstn(rstn), .clear(clear),
    .task_valid(task_valid), .task_ready(task_ready), .task_idx(task_idx),
    .task_addr(task_addr), .task_num(task_num),
    .data_valid(data_valid), .data_ready(data_ready), .data(data),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .done_valid(done_valid), .done_ready(done_ready), .done_idx(done_idx),
    .done_err(done_err)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    clear = 0; task_valid = 0; task_idx = 0; task_addr = 0; task_num = 0;
    data_valid = 0; data = 0; awready = 0; wready = 0;
    bvalid = 0; bresp = 0; done_ready = 0;
  endtask

  // Stimulus only: one burst with awready/wready/data_valid high. Ends on a
  // negedge with the DUT back in IDLE; ok reports beat count and termination.
  task automatic run_burst(input logic [1:0] idx, input logic [31:0] addr,
                           input logic [7:0] num, output bit ok);
    bit acc = 0, fin = 0;
    int beats = 0;
    int exp_beats = (num == 0) ? 256 : int'(num);
    @(negedge clk);
    task_valid = 1; task_idx = idx; task_addr = addr; task_num = num;
    awready = 1; wready = 1; data_valid = 1; data = 64'h0BAD_F00D_0000_0001;
    for (int c = 0; c < 600 && !fin; c++) begin
      #1;
      if (task_valid && task_ready) acc = 1;
      if (wvalid && wready) begin beats++; if (wlast) fin = 1; end
      @(negedge clk);
      if (acc) task_valid = 0;
    end
    data_valid = 0;
    ok = fin && (beats == exp_beats);
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 0;
    task_valid = 1; data_valid = 1; data = 64'hDEAD_BEEF_0123_4567;
    awready = 1; wready = 1; bvalid = 1;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if ({task_ready, data_ready, awvalid, wvalid, wlast, bready, done_valid, done_err} !== 8'b0000_0100) begin
      n_fail++;
      $display("FAIL rst_ctrl got=%b exp=00000100",
               {task_ready, data_ready, awvalid, wvalid, wlast, bready, done_valid, done_err});
    end
    n_tests++;
    if ({done_idx, awaddr, awlen, wdata} !== '0) begin
      n_fail++;
      $display("FAIL rst_data idx=%0d awaddr=%h awlen=%0d wdata=%h exp all 0", done_idx, awaddr, awlen, wdata);
    end
    idle_inputs();
    rstn = 1;
    #1;
    n_tests++;
    if (task_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release task_ready got=%b exp=1", task_ready); end
  endtask

  task automatic test_basic();
    @(negedge clk);
    task_valid = 1; task_idx = 2; task_addr = 32'h1000; task_num = 4;
    awready = 1; wready = 1;
    #1;
    n_tests++;
    if (task_ready !== 1'b1) begin n_fail++; $display("FAIL basic_task_ready got=%b exp=1", task_ready); end
    @(negedge clk);
    task_valid = 0;
    #1;
    n_tests++;
    if (awvalid !== 1'b1) begin n_fail++; $display("FAIL basic_aw_latency awvalid got=%b exp=1", awvalid); end
    n_tests++;
    if ({awaddr, awlen, awsize, awburst} !== {32'h1000, 8'd3, 3'd3, 2'b01}) begin
      n_fail++;
      $display("FAIL basic_aw_fields addr=%h len=%0d size=%0d burst=%b exp 1000/3/3/01", awaddr, awlen, awsize, awburst);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      data_valid = 1; data = 64'h100 + 64'(i);
      #1;
      n_tests++;
      if ({wvalid, data_ready, wlast} !== {1'b1, 1'b1, (i == 3)}) begin
        n_fail++;
        $display("FAIL basic_beat%0d wvalid/ready/last got=%b%b%b exp=11%b", i, wvalid, data_ready, wlast, (i == 3));
      end
      n_tests++;
      if (wdata !== 64'h100 + 64'(i) || wstrb !== 8'hFF) begin
        n_fail++;
        $display("FAIL basic_wdata%0d got=%h strb=%h exp=%h ff", i, wdata, wstrb, 64'h100 + 64'(i));
      end
    end
    @(negedge clk);
    data_valid = 0;
    #1;
    n_tests++;
    if ({awvalid, wvalid, data_ready, task_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL basic_back_idle aw/w/dr/tr got=%b exp=0001", {awvalid, wvalid, data_ready, task_ready});
    end
    bvalid = 1; bresp = 2'b00;
    #1;
    n_tests++;
    if (bready !== 1'b1) begin n_fail++; $display("FAIL basic_bready got=%b exp=1", bready); end
    @(negedge clk);
    bvalid = 0;
    #1;
    n_tests++;
    if ({done_valid, done_idx, done_err} !== {1'b1, 2'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_done v/idx/err got=%b/%0d/%b exp=1/2/0", done_valid, done_idx, done_err);
    end
    done_ready = 1;
    @(negedge clk);
    #1;
    n_tests++;
    if (done_valid !== 1'b0) begin n_fail++; $display("FAIL basic_done_clear got=%b exp=0", done_valid); end
    idle_inputs();
  endtask

  task automatic test_len256();
    bit acc = 0, fin = 0;
    int beats = 0, last_at = 0;
    logic [7:0] len_seen = 8'h00;
    @(negedge clk);
    task_valid = 1; task_idx = 1; task_addr = 32'h4000; task_num = 0;
    awready = 1; wready = 1; data_valid = 1; data = 64'h55;
    for (int c = 0; c < 400 && !fin; c++) begin
      #1;
      if (task_valid && task_ready) acc = 1;
      if (awvalid && awready) len_seen = awlen;
      if (wvalid && wready) begin
        beats++;
        if (wlast) begin last_at = beats; fin = 1; end
      end
      @(negedge clk);
      if (acc) task_valid = 0;
    end
    data_valid = 0;
    n_tests++;
    if (len_seen !== 8'd255) begin n_fail++; $display("FAIL len256_awlen got=%0d exp=255", len_seen); end
    n_tests++;
    if (beats != 256 || last_at != 256) begin
      n_fail++;
      $display("FAIL len256_beats beats=%0d wlast_at=%0d exp=256/256", beats, last_at);
    end
    bvalid = 1; done_ready = 1;
    @(negedge clk);
    bvalid = 0;
    #1;
    n_tests++;
    if ({done_valid, done_idx} !== {1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL len256_done v/idx got=%b/%0d exp=1/1", done_valid, done_idx);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_outstanding();
    int acc = 0, aws = 0;
    @(negedge clk);
    task_valid = 1; task_idx = 0; task_addr = 32'h8000; task_num = 1;
    awready = 1; wready = 1; data_valid = 1; done_ready = 1;
    for (int c = 0; c < 24; c++) begin
      #1;
      if (task_valid && task_ready) acc++;
      if (awvalid && awready) aws++;
      @(negedge clk);
      task_idx = 2'(acc);
    end
    #1;
    n_tests++;
    if (acc != 4 || aws != 4 || task_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL outst_limit accepted=%0d aw=%0d task_ready=%b exp=4/4/0", acc, aws, task_ready);
    end
    task_valid = 0;
    bvalid = 1; bresp = 0;
    #1;
    n_tests++;
    if (bready !== 1'b1) begin n_fail++; $display("FAIL outst_bready got=%b exp=1", bready); end
    @(negedge clk);
    bvalid = 0;
    #1;
    n_tests++;
    if ({task_ready, done_valid, done_idx} !== {1'b1, 1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL outst_reenable tr/dv/idx got=%b/%b/%0d exp=1/1/0", task_ready, done_valid, done_idx);
    end
    for (int k = 1; k < 4; k++) begin
      bvalid = 1;
      @(negedge clk);
      bvalid = 0;
      #1;
      n_tests++;
      if ({done_valid, done_idx} !== {1'b1, 2'(k)}) begin
        n_fail++;
        $display("FAIL outst_order%0d v/idx got=%b/%0d exp=1/%0d", k, done_valid, done_idx, k);
      end
    end
    @(negedge clk);
    bvalid = 1;
    #1;
    n_tests++;
    if (bready !== 1'b0) begin n_fail++; $display("FAIL stray_b_bready got=%b exp=0", bready); end
    @(negedge clk);
    bvalid = 0;
    #1;
    n_tests++;
    if (done_valid !== 1'b0) begin n_fail++; $display("FAIL stray_b_done got=%b exp=0", done_valid); end
    idle_inputs();
  endtask

  task automatic test_slverr();
    bit ok;
    run_burst(2'd1, 32'h100, 8'd1, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL slverr_burst1 ok=%b exp=1", ok); end
    run_burst(2'd3, 32'h200, 8'd2, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL slverr_burst2 ok=%b exp=1", ok); end
    done_ready = 0; bvalid = 1; bresp = 2'b10;
    #1;
    n_tests++;
    if (bready !== 1'b1) begin n_fail++; $display("FAIL slverr_bready got=%b exp=1", bready); end
    @(negedge clk);
    bresp = 2'b00;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if ({done_valid, done_err, done_idx, bready} !== {1'b1, 1'b1, 2'd1, 1'b0}) begin
        n_fail++;
        $display("FAIL slverr_hold%0d v/err/idx/bready got=%b/%b/%0d/%b exp=1/1/1/0",
                 i, done_valid, done_err, done_idx, bready);
      end
      @(negedge clk);
    end
    done_ready = 1;
    #1;
    n_tests++;
    if (bready !== 1'b1) begin n_fail++; $display("FAIL slverr_bready_release got=%b exp=1", bready); end
    @(negedge clk);
    bvalid = 0;
    #1;
    n_tests++;
    if ({done_valid, done_idx, done_err} !== {1'b1, 2'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL slverr_next v/idx/err got=%b/%0d/%b exp=1/3/0", done_valid, done_idx, done_err);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (done_valid !== 1'b0) begin n_fail++; $display("FAIL slverr_drain got=%b exp=0", done_valid); end
    idle_inputs();
  endtask

  task automatic test_clear();
    bit ok;
    run_burst(2'd2, 32'h300, 8'd1, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL clear_burst ok=%b exp=1", ok); end
    clear = 1;
    #1;
    n_tests++;
    if (task_ready !== 1'b0) begin n_fail++; $display("FAIL clear_task_ready got=%b exp=0", task_ready); end
    @(negedge clk);
    clear = 0; bvalid = 1; done_ready = 1;
    #1;
    n_tests++;
    if ({bready, task_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL clear_outst bready/task_ready got=%b%b exp=01", bready, task_ready);
    end
    @(negedge clk);
    bvalid = 0;
    #1;
    n_tests++;
    if (done_valid !== 1'b0) begin n_fail++; $display("FAIL clear_no_done got=%b exp=0", done_valid); end
    idle_inputs();
  endtask

  task automatic test_random_stalls();
    localparam int N = 100;
    logic [7:0]  q_num[$];
    logic [31:0] q_addr[$];
    logic [1:0]  q_done[$];
    int sent = 0, got = 0, beats = 0, b_pend = 0, cyc = 0;
    int cur_num = 0;
    bit t_acc = 0, aw_stall = 0, w_stall = 0;
    logic [31:0] p_awaddr = 0;
    logic [7:0]  p_awlen = 0;
    logic [63:0] p_wdata = 0;
    logic        p_wlast = 0;
    bit dv_hold = 0, bv_hold = 0;
    while (got < N && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      if (t_acc) begin task_valid = 0; t_acc = 0; end
      if (!task_valid && sent < N) begin
        task_valid = 1;
        task_idx   = 2'($urandom_range(0, 3));
        task_addr  = $urandom & 32'hFFFF_FFF8;
        task_num   = 8'($urandom_range(1, 16));
      end
      awready = ($urandom_range(0, 3) != 0);
      wready  = ($urandom_range(0, 3) != 0);
      if (!dv_hold) begin
        data_valid = ($urandom_range(0, 3) != 0);
        data = {$urandom, $urandom};
      end
      if (!bv_hold) bvalid = (b_pend > 0) && ($urandom_range(0, 1) == 1);
      bresp = 2'b00;
      done_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (aw_stall) begin
        n_tests++;
        if (awvalid !== 1'b1 || awaddr !== p_awaddr || awlen !== p_awlen) begin
          n_fail++;
          $display("FAIL rnd_aw_stable cyc=%0d v=%b addr=%h len=%0d exp=1/%h/%0d", cyc, awvalid, awaddr, awlen, p_awaddr, p_awlen);
        end
      end
      if (w_stall) begin
        n_tests++;
        if (wvalid !== 1'b1 || wdata !== p_wdata || wlast !== p_wlast) begin
          n_fail++;
          $display("FAIL rnd_w_stable cyc=%0d v=%b data=%h last=%b exp=1/%h/%b", cyc, wvalid, wdata, wlast, p_wdata, p_wlast);
        end
      end
      if (task_valid && task_ready) begin
        q_num.push_back(task_num); q_addr.push_back(task_addr); q_done.push_back(task_idx);
        sent++; t_acc = 1;
      end
      if (awvalid && awready) begin
        logic [7:0]  en;
        logic [31:0] ea;
        en = (q_num.size() > 0) ? q_num.pop_front() : 8'd0;
        ea = (q_addr.size() > 0) ? q_addr.pop_front() : 32'd0;
        cur_num = int'(en); beats = 0;
        n_tests++;
        if (awaddr !== ea || awlen !== en - 8'd1) begin
          n_fail++;
          $display("FAIL rnd_aw cyc=%0d addr=%h len=%0d exp=%h/%0d", cyc, awaddr, awlen, ea, en - 8'd1);
        end
      end
      if (wvalid && wready) begin
        beats++;
        n_tests++;
        if (wlast !== (beats == cur_num)) begin
          n_fail++;
          $display("FAIL rnd_wlast cyc=%0d beat=%0d of %0d wlast=%b", cyc, beats, cur_num, wlast);
        end
        if (wlast) b_pend++;
      end
      if (bvalid && bready) b_pend--;
      if (done_valid && done_ready) begin
        logic [1:0] ei;
        ei = (q_done.size() > 0) ? q_done.pop_front() : 2'd0;
        got++;
        n_tests++;
        if (done_idx !== ei || done_err !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_done #%0d idx=%0d err=%b exp=%0d/0", got, done_idx, done_err, ei);
        end
      end
      aw_stall = awvalid && !awready;
      w_stall  = wvalid && !wready;
      p_awaddr = awaddr; p_awlen = awlen; p_wdata = wdata; p_wlast = wlast;
      dv_hold  = data_valid && !data_ready;
      bv_hold  = bvalid && !bready;
    end
    n_tests++;
    if (got != N) begin n_fail++; $display("FAIL rnd_complete dones=%0d exp=%0d", got, N); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    task_valid = 1; task_idx = 2; task_addr = 32'h5000; task_num = 8;
    awready = 1; wready = 1; data_valid = 1; data = 64'hFACE_CAFE_1234_5678;
    @(negedge clk);
    task_valid = 0;
    repeat (4) @(negedge clk);
    rstn = 0;
    #1;
    n_tests++;
    if ({task_ready, data_ready, awvalid, wvalid, wlast, bready, done_valid, done_err} !== 8'b0000_0100) begin
      n_fail++;
      $display("FAIL midrst_ctrl got=%b exp=00000100",
               {task_ready, data_ready, awvalid, wvalid, wlast, bready, done_valid, done_err});
    end
    n_tests++;
    if ({done_idx, awaddr, awlen, wdata} !== '0) begin
      n_fail++;
      $display("FAIL midrst_data idx=%0d awaddr=%h awlen=%0d wdata=%h exp all 0", done_idx, awaddr, awlen, wdata);
    end
    repeat (2) @(negedge clk);
    idle_inputs();
    rstn = 1;
    @(negedge clk);
    task_valid = 1; task_idx = 3; task_addr = 32'h6000; task_num = 2;
    awready = 1; wready = 1;
    @(negedge clk);
    task_valid = 0; data_valid = 1; data = 64'h77;
    #1;
    n_tests++;
    if ({awvalid, awaddr, awlen} !== {1'b1, 32'h6000, 8'd1}) begin
      n_fail++;
      $display("FAIL midrst_aw v/addr/len got=%b/%h/%0d exp=1/6000/1", awvalid, awaddr, awlen);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if ({wvalid, wlast} !== 2'b10) begin n_fail++; $display("FAIL midrst_beat1 v/last got=%b%b exp=10", wvalid, wlast); end
    @(negedge clk);
    #1;
    n_tests++;
    if ({wvalid, wlast} !== 2'b11) begin n_fail++; $display("FAIL midrst_beat2 v/last got=%b%b exp=11", wvalid, wlast); end
    @(negedge clk);
    data_valid = 0; bvalid = 1; done_ready = 1;
    @(negedge clk);
    bvalid = 0;
    #1;
    n_tests++;
    if ({done_valid, done_idx, done_err} !== {1'b1, 2'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_done v/idx/err got=%b/%0d/%b exp=1/3/0", done_valid, done_idx, done_err);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len256();
    test_outstanding();
    test_slverr();
    test_clear();
    test_random_stalls();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
